// File: rtl/fixed_to_float.sv
// rtl/fixed_to_float.sv - 43-bit two's-complement fixed point to 16-bit float, 2-cycle latency.
// Optional macro FIX2FLT_ROUND_EN enables round-half-up on the dropped mantissa bits.
module fixed_to_float (
  input  logic        r_clk,
  input  logic        r_reset_n,
  input  logic [42:0] fixed_in,
  output logic [15:0] float_out
);

  logic        sign_c;
  logic [41:0] mag_c;
  logic [5:0]  lead_c;
  logic        found_c;
  logic [4:0]  exp_c;
  logic [9:0]  mant_c;

  logic        sign_r;
  logic [4:0]  exp_r;
  logic [9:0]  mant_r;

`ifdef FIX2FLT_ROUND_EN
  logic [10:0] sh_c;
  logic [10:0] mant_inc_c;
`endif

  always_comb begin
    sign_c = fixed_in[42];
    // Two's-complement negate of the low 42 bits equals ~(x - 1) truncated.
    mag_c  = sign_c ? 42'(~(fixed_in - 43'd1)) : fixed_in[41:0];
  end

  always_comb begin
    lead_c  = 6'd10;
    found_c = 1'b0;
    for (int k = 10; k < 42; k++) begin
      if (mag_c[k]) begin
        lead_c  = 6'(k);
        found_c = 1'b1;
      end
    end
  end

`ifdef FIX2FLT_ROUND_EN
  always_comb begin
    exp_c      = 5'(lead_c - 6'd10);
    // One extra LSB below the mantissa carries the round bit mag[i-11].
    sh_c       = 11'({mag_c, 1'b0} >> exp_c);
    mant_inc_c = {1'b0, sh_c[10:1]} + {10'd0, sh_c[0]};
    mant_c     = mant_inc_c[9:0];
    if (mant_inc_c[10]) begin
      if (exp_c == 5'd31) begin
        mant_c = 10'h3FF;
      end else begin
        exp_c  = exp_c + 5'd1;
        mant_c = 10'd0;
      end
    end
    if (!found_c) begin
      exp_c  = 5'd0;
      mant_c = 10'd0;
    end
  end
`else
  always_comb begin
    exp_c  = 5'(lead_c - 6'd10);
    mant_c = 10'(mag_c >> exp_c);
    if (!found_c) begin
      exp_c  = 5'd0;
      mant_c = 10'd0;
    end
  end
`endif

  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      sign_r <= 1'b0;
      exp_r  <= 5'd0;
      mant_r <= 10'd0;
    end else begin
      sign_r <= sign_c;
      exp_r  <= exp_c;
      mant_r <= mant_c;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      float_out <= 16'h0000;
    end else begin
      float_out <= {sign_r, exp_r, mant_r};
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// tb/tb_fixed_to_float.sv - randomized self-checking bench for fixed_to_float.
// Honours FIX2FLT_ROUND_EN in its reference model.
module tb_fixed_to_float;

  logic        r_clk;
  logic        r_reset_n;
  logic [42:0] fixed_in;
  logic [15:0] float_out;

  int n_checks;
  int n_fail;
  logic [15:0] prev_exp;

  fixed_to_float dut (
    .r_clk     (r_clk),
    .r_reset_n (r_reset_n),
    .fixed_in  (fixed_in),
    .float_out (float_out)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [15:0] model(input logic [42:0] x);
    longint v, mag, m;
    int e, ex;
    v = x[42] ? (longint'(x) - (longint'(1) << 43)) : longint'(x);
    mag = (v < 0) ? -v : v;
    mag = mag & ((longint'(1) << 42) - 1);
    if (mag < 1024) return {x[42], 15'd0};
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    ex = e - 10;
    m = mag >> ex;
`ifdef FIX2FLT_ROUND_EN
    if (ex > 0 && ((mag >> (ex - 1)) & 1) == 1) m = m + 1;
    if (m == 2048) begin
      ex = ex + 1;
      m = 1024;
    end
    if (ex > 31) begin
      ex = 31;
      m = 2047;
    end
`endif
    return {x[42], 5'(ex), 10'(m - 1024)};
  endfunction

  // Drive one cycle; returns the value float_out must hold just after this edge.
  task automatic drive(input logic [42:0] v, input logic rst_n, output logic [15:0] exp_now);
    fixed_in  = v;
    r_reset_n = rst_n;
    @(posedge r_clk);
    #1;
    exp_now  = !rst_n ? 16'h0000 : prev_exp;
    prev_exp = !rst_n ? 16'h0000 : model(v);
  endtask

  task automatic test_reset;
    logic [15:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(43'({$urandom, $urandom}), 1'b0, e);
      n_checks++;
      if (float_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h want 0000", i, float_out);
      end
    end
    drive(43'h800, 1'b1, e);
    n_checks++;
    if (float_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_release_first: got %h want 0000", float_out);
    end
    drive(43'h0, 1'b1, e);
    n_checks++;
    if (float_out !== 16'h0400) begin
      n_fail++;
      $display("FAIL reset_release_second: got %h want 0400", float_out);
    end
  endtask

  task automatic test_directed;
    logic [42:0] vin [9];
    logic [15:0] vexp [9];
    logic [15:0] e;
    vin[0] = 43'h800;           vexp[0] = 16'h0400;
    vin[1] = 43'hC00;           vexp[1] = 16'h0600;
    vin[2] = 43'h200_0000_0000; vexp[2] = 16'h7C00;
    vin[3] = 43'h3FF_FFFF_FFFF; vexp[3] = 16'h7FFF;
    vin[4] = 43'h7FF_FFFF_F800; vexp[4] = 16'h8400;
    vin[5] = 43'h7FF_FFFF_FFFF; vexp[5] = 16'h8000;
    vin[6] = 43'h400_0000_0000; vexp[6] = 16'h8000;
    vin[7] = 43'h3FF;           vexp[7] = 16'h0000;
    vin[8] = 43'h400;           vexp[8] = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      drive(vin[k], 1'b1, e);
      drive(43'h0, 1'b1, e);
      n_checks++;
      if (float_out !== vexp[k]) begin
        n_fail++;
        $display("FAIL directed[%0d] in=%h: got %h want %h", k, vin[k], float_out, vexp[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [42:0] vin [5];
    logic [15:0] want [5];
    logic [15:0] e;
    vin[0] = 43'h800; vin[1] = 43'hC00; vin[2] = 43'h1000; vin[3] = 43'h0; vin[4] = 43'h0;
    want[0] = 16'hxxxx; want[1] = 16'h0400; want[2] = 16'h0600; want[3] = 16'h0800; want[4] = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      drive(vin[k], 1'b1, e);
      if (k > 0) begin
        n_checks++;
        if (float_out !== want[k]) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got %h want %h", k, float_out, want[k]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] e;
    logic [42:0] v;
    logic        rst_n;
    for (int i = 0; i < 10000; i++) begin
      v = 43'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0: v = v >> $urandom_range(0, 42);
        1: v = ~(v >> $urandom_range(0, 42));
        default: ;
      endcase
      rst_n = !(i == 5000 || i == 5001);
      drive(v, rst_n, e);
      n_checks++;
      if (float_out !== e) begin
        n_fail++;
        $display("FAIL random[%0d] in=%h: got %h want %h", i, v, float_out, e);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    prev_exp  = 16'h0000;
    r_reset_n = 1'b0;
    fixed_in  = 43'h0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_to_float.md
Name: fixed_to_float

Overview:
- Pipelined converter from a 43-bit two's-complement fixed-point word to a 16-bit half-precision-style float word: sign, 5-bit exponent, 10-bit mantissa.
- Sits on the datapath between the fixed-point accumulator/MAC output and float-formatted storage or interfaces.
- Exponent is the leading-one position relative to bit 10; no bias, no inf/NaN encoding.
- Fixed 2-cycle latency; accepts a new input every cycle.

Parameters:
- None. Widths are fixed: 43-bit input, 16-bit output.

Ports:
- r_clk  input  1  clock; all state updates on rising edge.
- r_reset_n  input  1  synchronous, active-low reset.
- fixed_in  input  43  two's-complement fixed-point operand; bit 42 is the sign.
- float_out  output  16  registered result, {sign[15], exp[14:10], mant[9:0]}.

Behaviour:
- Reset is synchronous and active-low on r_reset_n, clocked by r_clk.
  - While r_reset_n = 0 at a rising edge, both pipeline stages clear to 0.
  - float_out = 16'h0000 from the first reset edge until valid data propagates.
  - A reset asserted mid-stream discards in-flight data; no partial results emerge.
- Stage 1, combinational then registered:
  - sign = fixed_in[42].
  - mag[41:0] = sign ? low 42 bits of ~(fixed_in − 1) : fixed_in[41:0]. This equals |fixed_in| truncated to 42 bits.
  - Leading-one search runs over mag[41:10] only. The highest set bit index i (10..41) gives exp = i − 10, range 0..31.
  - mant = low 10 bits of (mag >> (i − 10)), i.e. mag[i−1 : i−10]. The implicit leading one is dropped.
  - Lower bits are truncated; no rounding in the default build.
  - If mag[41:10] == 0: exp = 0, mant = 0, sign still passed through. So −1 → 16'h8000 and values below 2^10 flush to zero.
  - Most negative input, 43'h400_0000_0000: magnitude truncates to 0 → 16'h8000.
  - Registered: sign_r, exp_r, mant_r.
- Stage 2: float_out <= {sign_r, exp_r, mant_r}.
- Latency: input sampled at rising edge N appears on float_out after edge N+1. Throughput 1/cycle; no stall, no handshake.
- The priority encoder may be a loop or a tree. Critical path (42-bit negate + 32-bit priority encode + barrel shift) must fit one cycle; do not add stages, since latency is fixed at 2.

Optional Feature:
- Macro FIX2FLT_ROUND_EN.
- Undefined (default): truncation exactly as above.
- Defined: round-half-up on the dropped bits.
  - The increment is mag[i−11] when i ≥ 11. When i = 10 no bits are dropped.
  - Mantissa carry-out sets mant = 0 and exp + 1.
  - If exp would exceed 31, saturate to exp = 31, mant = 10'h3FF.
  - Latency stays 2; sign handling is unchanged.

Test Plan:
- Reset: hold r_reset_n = 0 for 5 cycles with random fixed_in → float_out = 16'h0000 throughout. Release → first result appears 2 edges after the first sampled input.
- Positive normals:
  - 43'h800 → 16'h0400.
  - 43'hC00 → 16'h0600.
  - 43'h200_0000_0000 (bit 41) → 16'h7C00.
  - 43'h3FF_FFFF_FFFF → 16'h7FFF (truncated; with FIX2FLT_ROUND_EN also 16'h7FFF via saturation).
- Negatives:
  - 43'h7FF_FFFF_F800 (−2048) → 16'h8400.
  - 43'h7FF_FFFF_FFFF (−1) → 16'h8000.
  - 43'h400_0000_0000 → 16'h8000.
- Underflow: 43'h3FF → 16'h0000; 43'h400 → 16'h0000 (exp 0, mant 0).
- Latency/throughput: back-to-back inputs 43'h800, 43'hC00, 43'h1000 on consecutive cycles → float_out 16'h0400, 16'h0600, 16'h0800 on consecutive cycles, each 2 edges after its input.
- Random regression: 10k random 43-bit inputs compared against a behavioural model (negate, leading one over bits 41..10, shift, truncate), delayed 2 cycles. Include a reset pulse mid-run → output 0 on the edge after reset, then resynchronises.
